// File: rtl/syn_m_pkg.sv
// Shared definitions for the master-path UTC info transmitter and its serial PHY.
package syn_m_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIRE = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } info_state_e;

  localparam logic [7:0]  HDR_DEFAULT     = 8'hA5;
  // start + 8 data + stop
  localparam int unsigned BITS_PER_BYTE   = 10;
  localparam logic [31:0] GPS_MIN_DEFAULT = 32'h00B70000;

endpackage

// File: rtl/syn_m_info_phy.sv
// Byte serialiser: start bit, eight data bits MSB-first, stop bit, each bit
// held for tbit_period clocks; done_tx marks the last cycle of the stop bit.
module syn_m_info_phy
  import syn_m_pkg::*;
#(
  parameter int unsigned TBIT_W = 10
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              fire_tx,
  input  logic [7:0]        data_tx,
  input  logic [TBIT_W-1:0] tbit_period,
  output logic              tx,
  output logic              done_tx
);

  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

  logic              active_r;
  logic              tx_r;
  logic [8:0]        shift_r;
  logic [3:0]        bit_cnt_r;
  logic [TBIT_W-1:0] per_cnt_r;
  logic              bit_end_s;
  logic              last_bit_s;

  // End of the current bit period and of the stop bit.
  always_comb begin
    bit_end_s  = (per_cnt_r == (tbit_period - TBIT_W'(1)));
    last_bit_s = (bit_cnt_r == LAST_BIT);
  end

  // Shift engine; a fire while a byte is in flight is ignored.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      active_r  <= 1'b0;
      tx_r      <= 1'b1;
      shift_r   <= 9'h1FF;
      bit_cnt_r <= 4'd0;
      per_cnt_r <= {TBIT_W{1'b0}};
    end else if (!active_r) begin
      if (fire_tx) begin
        active_r  <= 1'b1;
        tx_r      <= 1'b0;
        shift_r   <= {data_tx, 1'b1};
        bit_cnt_r <= 4'd0;
        per_cnt_r <= {TBIT_W{1'b0}};
      end
    end else if (bit_end_s) begin
      per_cnt_r <= {TBIT_W{1'b0}};
      if (last_bit_s) begin
        active_r <= 1'b0;
        tx_r     <= 1'b1;
      end else begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        tx_r      <= shift_r[8];
        shift_r   <= {shift_r[7:0], 1'b1};
      end
    end else begin
      per_cnt_r <= per_cnt_r + TBIT_W'(1);
    end
  end

  assign tx      = tx_r;
  assign done_tx = active_r & bit_end_s & last_bit_s;

endmodule

// File: rtl/syn_m_info_gen.sv
// UTC info transmitter on the master sync path: GPS-disciplined seconds register,
// continuity/overrun checks, and framed {HDR, UTC MSB-first} output on tx_info.
// Define SYN_INFO_CHK_EN to append an XOR checksum byte to every frame.
module syn_m_info_gen
  import syn_m_pkg::*;
#(
  parameter int unsigned NBYTE       = 4,
  parameter logic [7:0]  HDR         = HDR_DEFAULT,
  parameter int unsigned TBIT_PERIOD = 1000,
  parameter logic [31:0] GPS_MIN     = GPS_MIN_DEFAULT,
  parameter int unsigned DELAY_ADJ   = 1
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               fire_info,
  input  logic               fire_sync,
  input  logic [8*NBYTE-1:0] utc_sec_gps,
  output logic               tx_info,
  output logic               busy,
  output logic               frame_done,
  output logic               err,
  output logic               ovr,
  output logic [7:0]         err_cnt,
  output logic [8*NBYTE-1:0] utc_sec
);

  localparam int unsigned UW = 8 * NBYTE;
`ifdef SYN_INFO_CHK_EN
  localparam int unsigned NB = NBYTE + 2;
`else
  localparam int unsigned NB = NBYTE + 1;
`endif
  localparam int unsigned FW     = 8 * NB;
  localparam int unsigned IDX_W  = $clog2(NB);
  localparam int unsigned TBIT_W = $clog2(TBIT_PERIOD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

`ifdef SYN_INFO_CHK_EN
  function automatic logic [7:0] frame_chk(input logic [7:0] hdr, input logic [UW-1:0] t);
    logic [7:0] acc;
    acc = hdr;
    for (int i = 0; i < NBYTE; i++) begin
      acc = acc ^ t[8*i +: 8];
    end
    return acc;
  endfunction
`endif

  info_state_e      state_r;
  info_state_e      state_nxt_s;
  logic [UW-1:0]    utc_r;
  logic [UW-1:0]    utc_nxt_s;
  logic [UW-1:0]    gps_prev_r;
  logic             gps_valid_r;
  logic             gps_ok_s;
  logic             gap_err_s;
  logic             err_r;
  logic             ovr_r;
  logic [7:0]       err_cnt_r;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             frame_done_r;
  logic             fire_tx_s;
  logic [FW-1:0]    frame_r;
  logic [IDX_W-1:0] byte_idx_r;
  logic             done_tx_s;
  logic             tx_s;

  // GPS plausibility and continuity; the low 32 bits carry the plausibility test.
  always_comb begin
    gps_ok_s  = (32'(utc_sec_gps) > GPS_MIN) && (utc_sec_gps != gps_prev_r);
    gap_err_s = (fire_info | fire_sync) & gps_valid_r &
                (utc_sec_gps != (gps_prev_r + UW'(1)));
    if (gps_ok_s) begin
      utc_nxt_s = utc_sec_gps + UW'(DELAY_ADJ);
    end else begin
      utc_nxt_s = utc_r + UW'(1);
    end
  end

  // Time keeping and error reporting; runs regardless of frame activity.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      utc_r       <= {UW{1'b0}};
      gps_prev_r  <= {UW{1'b0}};
      gps_valid_r <= 1'b0;
      err_r       <= 1'b0;
      ovr_r       <= 1'b0;
      err_cnt_r   <= 8'd0;
    end else begin
      err_r <= gap_err_s;
      ovr_r <= fire_info & busy_r;
      if (gap_err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
      if (fire_info) begin
        utc_r       <= utc_nxt_s;
        gps_prev_r  <= utc_sec_gps;
        gps_valid_r <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a fire_info landing in DONE still starts a frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fire_info) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_FIRE;
      ST_FIRE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (done_tx_s) state_nxt_s = ST_GAP;
        else           state_nxt_s = ST_WAIT;
      end
      ST_GAP: begin
        if (byte_idx_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                        state_nxt_s = ST_FIRE;
      end
      ST_DONE: begin
        if (fire_info) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    fire_tx_s  = 1'b0;
    busy_nxt_s = 1'b0;
    case (state_r)
      ST_FIRE: fire_tx_s = 1'b1;
      default: fire_tx_s = 1'b0;
    endcase
    case (state_nxt_s)
      ST_LOAD, ST_FIRE, ST_WAIT, ST_GAP: busy_nxt_s = 1'b1;
      default:                           busy_nxt_s = 1'b0;
    endcase
  end

  // Frame snapshot and byte sequencing; the snapshot is frozen until the next LOAD.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      frame_r      <= {FW{1'b0}};
      byte_idx_r   <= {IDX_W{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= busy_nxt_s;
      frame_done_r <= (state_r == ST_DONE);
      if (state_r == ST_LOAD) begin
`ifdef SYN_INFO_CHK_EN
        frame_r <= {HDR, utc_r, frame_chk(HDR, utc_r)};
`else
        frame_r <= {HDR, utc_r};
`endif
        byte_idx_r <= {IDX_W{1'b0}};
      end else if (state_r == ST_GAP) begin
        frame_r    <= {frame_r[FW-9:0], 8'h00};
        byte_idx_r <= byte_idx_r + IDX_W'(1);
      end
    end
  end

  syn_m_info_phy #(
    .TBIT_W (TBIT_W)
  ) u_phy (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .fire_tx     (fire_tx_s),
    .data_tx     (frame_r[FW-1 -: 8]),
    .tbit_period (TBIT_W'(TBIT_PERIOD)),
    .tx          (tx_s),
    .done_tx     (done_tx_s)
  );

  assign tx_info    = tx_s;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;
  assign ovr        = ovr_r;
  assign err_cnt    = err_cnt_r;
  assign utc_sec    = utc_r;

endmodule

// File: doc/syn_m_info_gen.md
Name: syn_m_info_gen

Overview:
- Parametrised next-generation UTC info transmitter on the master sync path.
- Keeps a UTC-seconds register disciplined by GPS time. On each fire_info it serialises a framed message on tx_info: header byte, NBYTE time bytes, and an optional checksum byte.
- Adds checks the previous generation lacks: GPS continuity, overrun detection, error counting and a busy indication.
- Drives the bit-level line through an internal serial PHY sub-module.

Parameters:
- NBYTE, 4: time payload bytes; UTC width = 8*NBYTE.
- HDR, 8'hA5: frame header byte.
- TBIT_PERIOD, 1000: clk_sys cycles per line bit (1000 = 100 kbit/s at 100 MHz).
- GPS_MIN, 32'h00B70000: minimum plausible GPS time; compared on the low 32 bits.
- DELAY_ADJ, 1: seconds added when loading from GPS (MAC delay compensation).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset
- fire_info  in  1  one-cycle pulse: advance second and send frame
- fire_sync  in  1  one-cycle PPS pulse: continuity check only
- utc_sec_gps  in  8*NBYTE  GPS seconds, stable around pulses
- tx_info  out  1  serial line, idle high
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last stop bit
- err  out  1  one-cycle continuity error pulse
- ovr  out  1  one-cycle pulse: fire_info while busy
- err_cnt  out  8  saturating count of err pulses
- utc_sec  out  8*NBYTE  current UTC seconds

Behaviour:
- Reset is asynchronous, active-low on rst_n; the clock is clk_sys.
- Reset values: tx_info=1; busy, frame_done, err, ovr = 0; err_cnt=0; utc_sec=0; gps_prev=0; gps_valid=0; FSM in IDLE.
- UTC register, on a fire_info edge:
  - If utc_sec_gps > GPS_MIN and utc_sec_gps != gps_prev: utc_sec <= utc_sec_gps + DELAY_ADJ.
  - Otherwise: utc_sec <= utc_sec + 1, wrapping modulo 2^(8*NBYTE).
  - gps_prev <= utc_sec_gps; gps_valid <= 1.
- Continuity check:
  - On fire_info or fire_sync with gps_valid=1: if utc_sec_gps != gps_prev + 1, err pulses in the next cycle.
  - When both pulses arrive in the same cycle, exactly one check is made and it counts once.
  - err_cnt increments with each err pulse and saturates at 255.
- fire_info while busy: utc_sec and gps_prev still update, ovr pulses in the next cycle, and no new frame is queued. The in-flight frame is never altered.
- FSM states: IDLE, LOAD, FIRE, WAIT, GAP, DONE.
  - IDLE -> LOAD on fire_info at edge T.
  - LOAD (cycle T+1): snapshot frame = {HDR, utc_sec MSB-first, [chk]}; byte index = 0; busy = 1.
  - FIRE: one-cycle pulse to the PHY with the current byte; go to WAIT.
  - WAIT -> GAP on PHY done.
  - GAP: one cycle; return to FIRE if more bytes remain, otherwise go to DONE.
  - DONE: frame_done = 1, busy = 0, go to IDLE.
- The start bit of the header appears on tx_info at cycle T+3.
- PHY byte format: start 0, 8 data bits MSB-first, stop 1; each bit lasts TBIT_PERIOD cycles. done pulses on the last cycle of the stop bit.
- Frame duration is fixed: NB*(10*TBIT_PERIOD + 2) + 3 cycles, where NB = NBYTE+1, or NBYTE+2 with the checksum.
- Reset mid-frame: tx_info returns high immediately and no partial byte resumes.

Optional Feature:
- Macro SYN_INFO_CHK_EN.
- Defined: a trailing checksum byte is sent, equal to the XOR of HDR and all time bytes; frame length is NBYTE+2 bytes.
- Undefined: no checksum byte; frame length is NBYTE+1 bytes; the checksum logic is absent.

Decomposition:
- Shared package syn_m_pkg holds:
  - FSM state encodings;
  - HDR default;
  - the byte-format constant of 10 bits per byte;
  - GPS_MIN default.
- Sub-module syn_m_info_phy: byte serialiser with inputs fire_tx, data_tx[7:0] and tbit_period, and outputs tx and done_tx. It contains its own bit counter and period counter.

Test Plan:
- Reset release, TBIT_PERIOD=10, NBYTE=4, checksum off; fire_info with utc_sec_gps=32'h00B80000 -> utc_sec=32'h00B80001. Line carries A5,00,B8,00,01 (MSB-first). Start bit at T+3; frame_done after 5*102+3 = 513 cycles.
- Repeat the same GPS value on the next fire_info -> utc_sec=32'h00B80002. err pulses once (gps != prev+1); err_cnt=1.
- Good sequence 00B80000, 00B80001, 00B80002 across fire_sync/fire_info pulses -> no err.
- utc_sec_gps=32'h00000010 (below GPS_MIN) -> free-run increment; with utc_sec=FFFFFFFF it wraps to 0.
- fire_info mid-frame -> ovr pulse. In-flight bytes are unchanged; utc_sec is incremented; no second frame.
- With SYN_INFO_CHK_EN defined, utc=00B80001 -> 6th byte = A5^00^B8^00^01 = 1C. Reset asserted mid-byte -> tx_info=1 next cycle and busy=0.
